// File: rtl/evolver_pkg.sv
// Shared types and defaults for the projectile evolver: state encoding,
// level width and parameter defaults.
package evolver_pkg;

    localparam int LEVEL_W = 2;

    localparam int DEF_MAX_LEVEL      = 3;
    localparam int DEF_FIRE_THRESHOLD = 2;
    localparam int DEF_COOLDOWN_TICKS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_FULL   = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_COOL   = 3'd4
    } state_t;

    function automatic int cnt_width(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/projectile_evolver_if.sv
// Shot handshake bundle: evolver offers a shot, downstream accepts it.
interface projectile_evolver_if;

    logic                              shot_valid;
    logic                              shot_ready;
    logic [evolver_pkg::LEVEL_W-1:0]   shot_level;
    logic                              shot_fire;

    modport master (output shot_valid, output shot_level, output shot_fire,
                    input  shot_ready);
    modport slave  (input  shot_valid, input  shot_level, input  shot_fire,
                    output shot_ready);

endinterface

// File: rtl/projectile_evolver_tick_counter.sv
// Cooldown tick counter: synchronous clear, enable, terminal-count compare.
module tick_counter #(
    parameter int TICKS = 4,
    parameter int W     = $clog2(TICKS + 1)
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    // High when the next enabled tick brings the count up to TICKS.
    assign last = (count == W'(TICKS - 1));

endmodule

// File: rtl/projectile_evolver.sv
// Charge-shot controller: builds charge level on evolve ticks, offers the
// shot over a valid/ready handshake, then cools down for a number of ticks.
//
//  state  | meaning
//  IDLE   | waiting for the fire button, level held at 0
//  CHARGE | button held, each tick raises the level
//  FULL   | level saturated at MAX_LEVEL, ticks ignored
//  LAUNCH | shot offered downstream until accepted
//  COOL   | counting cooldown ticks, button ignored
module projectile_evolver
    import evolver_pkg::*;
#(
    parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
    parameter int FIRE_THRESHOLD = DEF_FIRE_THRESHOLD,
    parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               charge,
    input  logic               evolve_tick,
    output logic               counter_clr,
    output logic [LEVEL_W-1:0] level,
    output logic               is_fire,
    output logic               busy,
    projectile_evolver_if.master shot
);

    localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] FIRE_L = LEVEL_W'(FIRE_THRESHOLD);

    state_t               state, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [LEVEL_W-1:0]   shot_level_q, shot_level_d;
    logic                 shot_fire_q, shot_fire_d;
    logic [LEVEL_W-1:0]   level_inc;
    logic                 cool_last;

    tick_counter #(
        .TICKS (COOLDOWN_TICKS),
        .W     (cnt_width(COOLDOWN_TICKS))
    ) u_cool_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .clr   (state != ST_COOL),
        .en    (evolve_tick),
        .last  (cool_last)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= ST_IDLE;
            level_q      <= '0;
            shot_level_q <= '0;
            shot_fire_q  <= 1'b0;
        end else begin
            state        <= state_d;
            level_q      <= level_d;
            shot_level_q <= shot_level_d;
            shot_fire_q  <= shot_fire_d;
        end
    end

    assign level_inc = level_q + 1'b1;

    always_comb begin
        state_d      = state;
        level_d      = level_q;
        shot_level_d = shot_level_q;
        shot_fire_d  = shot_fire_q;
        case (state)
            ST_IDLE: begin
                level_d = '0;
                if (charge)
                    state_d = ST_CHARGE;
            end
            ST_CHARGE: begin
                // Release wins over a coincident tick: shot uses pre-tick level.
                if (!charge) begin
                    if (level_q != '0) begin
                        state_d      = ST_LAUNCH;
                        shot_level_d = level_q;
                        shot_fire_d  = (level_q >= FIRE_L);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (evolve_tick) begin
                    level_d = level_inc;
                    if (level_inc == MAX_L)
                        state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!charge) begin
                    state_d      = ST_LAUNCH;
                    shot_level_d = level_q;
                    shot_fire_d  = (level_q >= FIRE_L);
                end
            end
            ST_LAUNCH: begin
                if (shot.shot_ready) begin
                    state_d = ST_COOL;
                    level_d = '0;
                end
            end
            ST_COOL: begin
                if (evolve_tick && cool_last)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                level_d = '0;
            end
        endcase
    end

    assign level           = level_q;
    assign is_fire         = (level_q >= FIRE_L);
    assign busy            = (state != ST_IDLE);
    assign counter_clr     = (state == ST_IDLE) || (state == ST_LAUNCH);
    assign shot.shot_valid = (state == ST_LAUNCH);
    assign shot.shot_level = shot_level_q;
    assign shot.shot_fire  = shot_fire_q;

endmodule

// File: tb/tb_projectile_evolver.sv
// Self-checking bench: directed scenarios plus random charge/tick/ready
// traffic against a behavioural model of the charge-shot rules.
module tb_projectile_evolver;

    localparam int MAXL   = 3;
    localparam int FIRE_T = 2;
    localparam int CD     = 4;

    localparam int P_IDLE = 0;
    localparam int P_CHG  = 1;
    localparam int P_SHOT = 2;
    localparam int P_COOL = 3;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       charge;
    logic       evolve_tick;
    logic       counter_clr;
    logic [1:0] level;
    logic       is_fire;
    logic       busy;

    projectile_evolver_if sif ();

    projectile_evolver #(
        .MAX_LEVEL      (MAXL),
        .FIRE_THRESHOLD (FIRE_T),
        .COOLDOWN_TICKS (CD)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .charge      (charge),
        .evolve_tick (evolve_tick),
        .counter_clr (counter_clr),
        .level       (level),
        .is_fire     (is_fire),
        .busy        (busy),
        .shot        (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int phase, m_lvl, m_sl, m_sf, m_cool;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase  = P_IDLE;
        m_lvl  = 0;
        m_sl   = 0;
        m_sf   = 0;
        m_cool = 0;
    endtask

    task automatic model_step(input bit c, input bit t, input bit r);
        case (phase)
            P_IDLE: if (c) phase = P_CHG;
            P_CHG: begin
                if (!c) begin
                    if (m_lvl > 0) begin
                        phase = P_SHOT;
                        m_sl  = m_lvl;
                        m_sf  = (m_lvl >= FIRE_T) ? 1 : 0;
                    end else begin
                        phase = P_IDLE;
                    end
                end else if (t && m_lvl < MAXL) begin
                    m_lvl++;
                end
            end
            P_SHOT: if (r) begin
                phase  = P_COOL;
                m_lvl  = 0;
                m_cool = 0;
            end
            default: if (t) begin
                m_cool++;
                if (m_cool == CD) phase = P_IDLE;
            end
        endcase
    endtask

    task automatic compare_all();
        chk("level",       int'(level),          m_lvl);
        chk("is_fire",     int'(is_fire),        (m_lvl >= FIRE_T) ? 1 : 0);
        chk("busy",        int'(busy),           (phase != P_IDLE) ? 1 : 0);
        chk("counter_clr", int'(counter_clr),    (phase == P_IDLE || phase == P_SHOT) ? 1 : 0);
        chk("shot_valid",  int'(sif.shot_valid), (phase == P_SHOT) ? 1 : 0);
        chk("shot_level",  int'(sif.shot_level), m_sl);
        chk("shot_fire",   int'(sif.shot_fire),  m_sf);
    endtask

    task automatic cycle(input bit c, input bit t, input bit r);
        charge         = c;
        evolve_tick    = t;
        sif.shot_ready = r;
        @(posedge clk);
        model_step(c, t, r);
        #1;
        compare_all();
    endtask

    // Asynchronous pulse placed mid-cycle, released on the falling edge.
    task automatic do_reset();
        #2;
        clr_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid",   int'(sif.shot_valid), 0);
        chk("rst_level",   int'(level),          0);
        chk("rst_busy",    int'(busy),           0);
        chk("rst_cclr",    int'(counter_clr),    1);
        chk("rst_is_fire", int'(is_fire),        0);
        chk("rst_slevel",  int'(sif.shot_level), 0);
        chk("rst_sfire",   int'(sif.shot_fire),  0);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        bit c, t, r;
        clr_n          = 1'b0;
        charge         = 1'b0;
        evolve_tick    = 1'b0;
        sif.shot_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        clr_n = 1'b1;

        // Charge to full and saturate.
        cycle(1, 0, 0);
        chk("chg_busy", int'(busy), 1);
        cycle(1, 1, 0); chk("lvl_t1", int'(level), 1);
        chk("fire_t1", int'(is_fire), 0);
        cycle(1, 1, 0); chk("lvl_t2", int'(level), 2);
        chk("fire_t2", int'(is_fire), 1);
        cycle(1, 1, 0); chk("lvl_t3", int'(level), 3);
        cycle(1, 1, 0); chk("lvl_sat", int'(level), 3);
        cycle(1, 1, 0); chk("lvl_sat2", int'(level), 3);
        cycle(0, 0, 1); chk("full_launch", int'(sif.shot_level), 3);
        cycle(0, 0, 1);
        repeat (CD) cycle(0, 1, 0);
        chk("cool_done", int'(busy), 0);

        // Level-1 shot accepted at once.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 1, 1);
        cycle(0, 0, 1);
        chk("l1_valid", int'(sif.shot_valid), 1);
        chk("l1_slevel", int'(sif.shot_level), 1);
        chk("l1_sfire", int'(sif.shot_fire), 0);
        cycle(0, 0, 1);
        chk("l1_valid_drop", int'(sif.shot_valid), 0);
        chk("l1_cool_busy", int'(busy), 1);

        // Cooldown with button held, then re-entry.
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("cool3_busy", int'(busy), 1);
        cycle(1, 1, 0);
        chk("cool4_idle", int'(busy), 0);
        chk("cool4_cclr", int'(counter_clr), 1);
        cycle(1, 0, 0);
        chk("reentry_busy", int'(busy), 1);
        chk("reentry_cclr", int'(counter_clr), 0);

        // Level-2 shot held under backpressure.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0);
            chk("bp_valid", int'(sif.shot_valid), 1);
            chk("bp_slevel", int'(sif.shot_level), 2);
            chk("bp_sfire", int'(sif.shot_fire), 1);
        end
        cycle(0, 0, 1);
        chk("bp_accept", int'(sif.shot_valid), 0);

        // Tick coinciding with release.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        chk("coinc_slevel", int'(sif.shot_level), 1);
        chk("coinc_level", int'(level), 1);

        // Release at level 0 returns quietly.
        do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        chk("l0_idle", int'(busy), 0);
        chk("l0_novalid", int'(sif.shot_valid), 0);

        // Reset during LAUNCH aborts the shot.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(0, 0, 0);
        chk("pre_abort_valid", int'(sif.shot_valid), 1);
        sif.shot_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            chk("abort_novalid", int'(sif.shot_valid), 0);
        end

        // Random traffic.
        c = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) c = ~c;
            t = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 1);
            cycle(c, t, r);
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
